serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial, LSB-first subtractor computing diff = a - b - bin over WIDTH clocks, with a start/busy/done handshake. It is the inverse-direction counterpart of the team's combinational ripple adder. It trades area for latency: one full-subtractor cell plus a borrow flop. It sits beside the adder in the arithmetic basics library, and the same operand patterns are used to cross-check the two.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while in IDLE
a  input  WIDTH  minuend, unsigned (two's complement when the overflow feature is used)
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
busy  output  1  high while in SHIFT or DONE
done  output  1  one-cycle pulse; diff/bout valid
diff  output  WIDTH  result a - b - bin, mod 2^WIDTH
bout  output  1  borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal operand shift registers, borrow flop and bit counter are all cleared.
  - rst has priority over every other input.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E latches a->A, b->B and bin->borrow, clears counter to 0, and moves to SHIFT.
  - start=0: stay in IDLE; diff/bout hold their last value.
- SHIFT, one bit per cycle:
  - d = A[0]^B[0]^borrow.
  - borrow <= (~A[0]&B[0]) | (~(A[0]^B[0])&borrow).
  - A and B shift right by 1; the diff shift register shifts right with d inserted at its MSB.
  - counter increments each cycle; when counter == WIDTH-1, the next state is DONE.
- DONE, exactly one cycle:
  - done=1; diff holds the full result; bout = final borrow.
  - Next state is IDLE.
- Latency: SHIFT spans edges E+1..E+WIDTH; done is high in the cycle after edge E+WIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored: no re-latch and no queueing.
- a, b and bin may change freely after edge E; only the latched copies are used.
- diff and bout change only at the end of SHIFT. They hold after done until the next completed operation. The diff register contents are not guaranteed to be a valid result while busy=1.
- rst mid-operation aborts immediately: outputs go to their reset values, no done pulse, return to IDLE.
- Counter width is clog2(WIDTH)+1 bits, so there is no wrap within one operation.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit): two's-complement overflow of a - b.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), where a_msb and b_msb are taken from the latched operands.
  - Registered with diff; cleared by reset; held like diff.
- Not defined:
  - Port ovf is absent and no MSB-capture logic is generated.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=4, reset then a=5, b=3, bin=0, start 1 cycle -> done after 5 cycles; diff=2, bout=0; busy high for exactly 5 cycles.
2. a=3, b=5, bin=0 -> diff=4'hE, bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
3. Exhaustive sweep of a, b in 0..15, bin in {0,1} (512 operations) -> {bout,diff} equals {1'b0,a} - b - bin every time; done pulses are exactly one cycle wide.
4. Start a=9, b=2; hold start=1 and drive a=0, b=0 during SHIFT -> single done; diff=7, bout=0; no second operation starts until IDLE.
5. Start a=12, b=4; assert rst for 1 cycle at SHIFT cycle 2 -> no done; diff=0, bout=0, busy=0 the next cycle. A fresh start a=1, b=1 -> diff=0, bout=0.
6. With SERIAL_SUB_OVF_EN: a=4'h7, b=4'h8 -> diff=4'hF, ovf=1; a=4'h8, b=4'h1 -> diff=4'h7, ovf=1; a=4'h3, b=4'h1 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor
// ----------------------------------------------------------------------------
// Bit-serial, LSB-first subtractor: diff = a - b - bin (mod 2^WIDTH), one
// bit per clock through a single full-subtractor cell and a borrow flop.
// Operands are latched on the start edge; the result appears on diff/bout
// when done pulses and is held until the next completed operation.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..16)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (highest priority)
//   start  in   request, sampled only while idle
//   a      in   minuend  [WIDTH-1:0]
//   b      in   subtrahend [WIDTH-1:0]
//   bin    in   borrow-in
//   busy   out  high while shifting or presenting the result
//   done   out  one-cycle pulse, diff/bout valid
//   diff   out  result [WIDTH-1:0]
//   bout   out  borrow-out (a < b + bin, unsigned)
//   ovf    out  two's-complement overflow of a - b
//               (only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter is one bit wider than needed to index WIDTH-1, so it cannot
    // wrap inside a single operation.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced before the final one; the final
    // bit is merged in directly when the output register is loaded.
    logic [WIDTH-2:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             last_bit;
    logic             d_bit;
    logic             borrow_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // ------------------------------------------------------------------
    // Full-subtractor cell
    // ------------------------------------------------------------------
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    assign d_bit      = fs_diff(a_sr[0], b_sr[0], borrow);
    assign borrow_nxt = fs_borrow(a_sr[0], b_sr[0], borrow);
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, serial shift, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    // New bit enters at the top so the LSB-first stream
                    // ends up in natural bit order.
                    d_sr   <= (d_sr >> 1) | ((WIDTH-1)'(d_bit) << (WIDTH - 2));
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff <= {d_bit, d_sr};
                        bout <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // d_bit is the result MSB on the final step.
                        ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
